srgate_multi: RTL and testbench

- Parametrised multi-channel successor to the single-channel SR gate.
- NCH independent set/reset latches; each has its own enable, set/reset edge selection, disabled-state policy and masked force strobes.
- Sits in the PandA bit-bus fabric: bit-bus inputs in, registered bit outputs back to the bus, with register-block controls.

---
 rtl/srgate_pkg.sv | 35 +++
 rtl/srgate_chan.sv | 133 +++++++++++++
 rtl/srgate_multi.sv | 71 +++++++
 tb/tb_srgate_multi.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/srgate_pkg.sv
// srgate_pkg: shared types and helpers for the multi-channel SR gate.
//
// Contents:
//   EDGE_W, DIS_W  widths of the per-channel edge-select and disabled-policy fields
//   edge_sel_t     edge selection: RISING, FALLING, EITHER, NONE
//   dis_mode_t     disabled-state policy: LOW, HIGH, HOLD (raw code 3 behaves as LOW)
//   edge_hit()     evaluates one edge selector against current/previous samples
package srgate_pkg;

  localparam int EDGE_W = 2;
  localparam int DIS_W  = 2;

  typedef enum logic [EDGE_W-1:0] {
    RISING  = 2'd0,
    FALLING = 2'd1,
    EITHER  = 2'd2,
    NONE    = 2'd3
  } edge_sel_t;

  typedef enum logic [DIS_W-1:0] {
    LOW  = 2'd0,
    HIGH = 2'd1,
    HOLD = 2'd2
  } dis_mode_t;

  function automatic logic edge_hit(edge_sel_t sel, logic cur, logic prev);
    case (sel)
      RISING:  return cur & ~prev;
      FALLING: return ~cur & prev;
      EITHER:  return cur ^ prev;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/srgate_chan.sv
// srgate_chan: one set/reset latch channel of srgate_multi.
//
// Stage 1 samples the inputs, detects edges against the previous sample and
// registers the resulting events together with enable and the force strobes.
// Stage 2 applies them in priority order to the output register, which gives
// exactly one clock of latency from an input sample to out_o.
//
// Optional feature (macro SRGATE_TIMEOUT_EN): per-channel TW-bit counter that
// drops out_o after it has been high for `timeout` clocks (0 = off).
//
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   enable_i             channel enable
//   set_i, rst_i         set / reset inputs
//   when_disabled        disabled-state policy (dis_mode_t encoding)
//   set_edge, rst_edge   edge selection (edge_sel_t encoding)
//   force_set, force_rst already-masked force strobes
//   timeout              auto-reset period (only with SRGATE_TIMEOUT_EN)
//   out_o                latched output
module srgate_chan
  import srgate_pkg::*;
`ifdef SRGATE_TIMEOUT_EN
#(
  parameter int TW = 32
)
`endif
(
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic              set_i,
  input  logic              rst_i,
  input  logic [DIS_W-1:0]  when_disabled,
  input  logic [EDGE_W-1:0] set_edge,
  input  logic [EDGE_W-1:0] rst_edge,
  input  logic              force_set,
  input  logic              force_rst,
`ifdef SRGATE_TIMEOUT_EN
  input  logic [TW-1:0]     timeout,
`endif
  output logic              out_o
);

  logic set_q, rst_q, primed_q;
  logic set_ev_q, rst_ev_q, en_q, fset_q, frst_q;
  logic out_q, out_d;

`ifdef SRGATE_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;
  logic          expire;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      set_q    <= 1'b0;
      rst_q    <= 1'b0;
      primed_q <= 1'b0;
      set_ev_q <= 1'b0;
      rst_ev_q <= 1'b0;
      en_q     <= 1'b0;
      fset_q   <= 1'b0;
      frst_q   <= 1'b0;
      out_q    <= 1'b0;
`ifdef SRGATE_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      // History tracks even while disabled so re-enabling sees no stale edge.
      set_q    <= set_i;
      rst_q    <= rst_i;
      primed_q <= 1'b1;
      // Until primed the history holds reset zeros, not real samples.
      set_ev_q <= primed_q & edge_hit(edge_sel_t'(set_edge), set_i, set_q);
      rst_ev_q <= primed_q & edge_hit(edge_sel_t'(rst_edge), rst_i, rst_q);
      en_q     <= enable_i;
      fset_q   <= force_set;
      frst_q   <= force_rst;
      out_q    <= out_d;
`ifdef SRGATE_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

`ifdef SRGATE_TIMEOUT_EN
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (!out_q || (en_q && (fset_q || set_ev_q))) begin
      cnt_d = '0;
    end else if (en_q) begin
      cnt_d = cnt_q + TW'(1);
    end
    // ">=" so a TIMEOUT lowered below the running count expires at once.
    if (en_q && out_q && (timeout != '0) && (cnt_q >= timeout - TW'(1))) begin
      expire = 1'b1;
    end
  end
`endif

  always_comb begin
    out_d = out_q;
    if (!primed_q) begin
      // Stage-1 registers still hold reset values on this cycle.
      out_d = out_q;
    end else if (!en_q) begin
      case (dis_mode_t'(when_disabled))
        HIGH:    out_d = 1'b1;
        HOLD:    out_d = out_q;
        default: out_d = 1'b0;
      endcase
    end else if (frst_q) begin
      out_d = 1'b0;
    end else if (fset_q) begin
      out_d = 1'b1;
    end else if (rst_ev_q) begin
      out_d = 1'b0;
    end else if (set_ev_q) begin
      out_d = 1'b1;
`ifdef SRGATE_TIMEOUT_EN
    end else if (expire) begin
      out_d = 1'b0;
`endif
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/srgate_multi.sv
// srgate_multi: NCH independent set/reset gates on the bit bus.
//
// Each channel has its own enable, set/reset edge selection and disabled
// policy; the force strobes are shared and qualified per channel by FORCE_MASK.
// Optional feature (macro SRGATE_TIMEOUT_EN): TIMEOUT port and per-channel
// auto-reset counters.
//
// Parameters: NCH channels (1..32), TW timeout counter width.
// Ports:
//   clk_i, reset_n_i               clock, asynchronous active-low reset
//   enable_i, set_i, rst_i         per-channel bit-bus inputs
//   out_o                          per-channel registered outputs
//   WHEN_DISABLED                  2 bits/channel: 0 low, 1 high, 2 hold, 3 low
//   SET_EDGE, RST_EDGE             2 bits/channel: 0 rise, 1 fall, 2 either, 3 none
//   FORCE_SET_WSTB, FORCE_RST_WSTB single-cycle force strobes
//   FORCE_MASK                     channels affected by the force strobes
//   TIMEOUT                        auto-reset period, 0 = off (SRGATE_TIMEOUT_EN)
module srgate_multi
  import srgate_pkg::*;
#(
  parameter int NCH = 4,
  parameter int TW  = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [NCH-1:0]        enable_i,
  input  logic [NCH-1:0]        set_i,
  input  logic [NCH-1:0]        rst_i,
  output logic [NCH-1:0]        out_o,
  input  logic [DIS_W*NCH-1:0]  WHEN_DISABLED,
  input  logic [EDGE_W*NCH-1:0] SET_EDGE,
  input  logic [EDGE_W*NCH-1:0] RST_EDGE,
  input  logic                  FORCE_SET_WSTB,
  input  logic                  FORCE_RST_WSTB,
  input  logic [NCH-1:0]        FORCE_MASK
`ifdef SRGATE_TIMEOUT_EN
  ,
  input  logic [TW-1:0]         TIMEOUT
`endif
);

  // An out-of-range parameterisation builds an inert block rather than a
  // partially connected channel array.
  if (NCH >= 1 && NCH <= 32 && TW >= 1) begin : g_chans
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      srgate_chan
`ifdef SRGATE_TIMEOUT_EN
        #(.TW(TW))
`endif
      u_chan (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .enable_i      (enable_i[i]),
        .set_i         (set_i[i]),
        .rst_i         (rst_i[i]),
        .when_disabled (WHEN_DISABLED[i*DIS_W +: DIS_W]),
        .set_edge      (SET_EDGE[i*EDGE_W +: EDGE_W]),
        .rst_edge      (RST_EDGE[i*EDGE_W +: EDGE_W]),
        .force_set     (FORCE_SET_WSTB & FORCE_MASK[i]),
        .force_rst     (FORCE_RST_WSTB & FORCE_MASK[i]),
`ifdef SRGATE_TIMEOUT_EN
        .timeout       (TIMEOUT),
`endif
        .out_o         (out_o[i])
      );
    end
  end else begin : g_bad_params
    assign out_o = '0;
  end

endmodule

// File: tb/tb_srgate_multi.sv
// tb_srgate_multi: scoreboard bench for srgate_multi (NCH=4).
// Stimulus pushes the expected out_o (with a channel mask) after each rising
// edge; the monitor pops and compares on the following falling edge.
// Timeout scenarios are built only when SRGATE_TIMEOUT_EN is defined.
module tb_srgate_multi;

  localparam int NCH = 4;
  localparam int TW  = 32;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic [NCH-1:0]   enable_i, set_i, rst_i, out_o;
  logic [2*NCH-1:0] WHEN_DISABLED, SET_EDGE, RST_EDGE;
  logic             FORCE_SET_WSTB, FORCE_RST_WSTB;
  logic [NCH-1:0]   FORCE_MASK;
`ifdef SRGATE_TIMEOUT_EN
  logic [TW-1:0]    TIMEOUT;
`endif

  srgate_multi #(.NCH(NCH), .TW(TW)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .enable_i       (enable_i),
    .set_i          (set_i),
    .rst_i          (rst_i),
    .out_o          (out_o),
    .WHEN_DISABLED  (WHEN_DISABLED),
    .SET_EDGE       (SET_EDGE),
    .RST_EDGE       (RST_EDGE),
    .FORCE_SET_WSTB (FORCE_SET_WSTB),
    .FORCE_RST_WSTB (FORCE_RST_WSTB),
    .FORCE_MASK     (FORCE_MASK)
`ifdef SRGATE_TIMEOUT_EN
    ,
    .TIMEOUT        (TIMEOUT)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string          name;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(string name, logic [NCH-1:0] act, logic [NCH-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: out_o=%b required %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare every expectation queued since the last falling edge.
  always @(negedge clk_i) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      check(cur.name, out_o & cur.mask, cur.exp & cur.mask);
    end
  end

  // One clock: wait for the rising edge, queue the expected post-edge value
  // (mask 0 = do not check), return on the falling edge ready to drive.
  task automatic tick(string name, logic [NCH-1:0] mask, logic [NCH-1:0] exp);
    @(posedge clk_i);
    if (mask != '0) sb.push_back('{name: name, mask: mask, exp: exp});
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n_i      = 1'b1;
    enable_i       = '1;
    set_i          = 4'b0001;
    rst_i          = '0;
    WHEN_DISABLED  = '0;
    SET_EDGE       = '0;
    RST_EDGE       = '0;
    FORCE_SET_WSTB = 1'b0;
    FORCE_RST_WSTB = 1'b0;
    FORCE_MASK     = '0;
`ifdef SRGATE_TIMEOUT_EN
    TIMEOUT        = '0;
`endif
    #2 reset_n_i = 1'b0;
    #1 check("reset_state", out_o, '0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;

    // Priming: set_i[0] high across release is not a rising edge.
    tick("prime0", 4'b0001, 4'b0000);
    tick("prime1", 4'b0001, 4'b0000);
    tick("prime2", 4'b0001, 4'b0000);
    set_i[0] = 1'b0;
    tick("ch0_fall_ignored", 4'b0001, 4'b0000);
    tick("ch0_fall_ignored", 4'b0001, 4'b0000);
    set_i[0] = 1'b1;
    tick("ch0_set_latency", 4'b0001, 4'b0000);
    tick("ch0_set", 4'b0001, 4'b0001);

    // Ch1: set on falling, reset on either edge.
    SET_EDGE[3:2] = 2'd1;
    RST_EDGE[3:2] = 2'd2;
    set_i[1] = 1'b1;
    tick("ch1_rise_ignored", 4'b0010, 4'b0000);
    tick("ch1_rise_ignored", 4'b0010, 4'b0000);
    set_i[1] = 1'b0;
    tick("ch1_fall_latency", 4'b0010, 4'b0000);
    tick("ch1_set_fall", 4'b0010, 4'b0010);
    rst_i[1] = 1'b1;
    tick("ch1_rst_latency", 4'b0010, 4'b0010);
    tick("ch1_rst_rise", 4'b0010, 4'b0000);
    rst_i[1] = 1'b0;
    tick("ch1_rst_fall", 4'b0010, 4'b0000);
    tick("ch1_rst_fall", 4'b0010, 4'b0000);
    set_i[1] = 1'b1;
    tick("", '0, '0);
    tick("", '0, '0);
    set_i[1] = 1'b0;
    tick("", '0, '0);
    tick("ch1_reset_again", 4'b0010, 4'b0010);
    set_i[1] = 1'b1;
    tick("ch1_hold", 4'b0010, 4'b0010);
    tick("ch1_hold", 4'b0010, 4'b0010);
    set_i[1] = 1'b0;
    rst_i[1] = 1'b1;
    tick("ch1_both_latency", 4'b0010, 4'b0010);
    tick("ch1_both_rst_wins", 4'b0010, 4'b0000);
    tick("chan_independent", 4'b1111, 4'b0001);

    // Masked force strobes.
    FORCE_MASK     = 4'b0101;
    FORCE_SET_WSTB = 1'b1;
    tick("force_set_latency", 4'b1111, 4'b0001);
    FORCE_SET_WSTB = 1'b0;
    tick("force_set_masked", 4'b1111, 4'b0101);
    FORCE_MASK     = 4'b1111;
    FORCE_SET_WSTB = 1'b1;
    FORCE_RST_WSTB = 1'b1;
    tick("force_both_latency", 4'b1111, 4'b0101);
    FORCE_SET_WSTB = 1'b0;
    FORCE_RST_WSTB = 1'b0;
    tick("force_both_rst_wins", 4'b1111, 4'b0000);

    // Ch2 disabled-state policies.
    set_i[2] = 1'b1;
    tick("ch2_set_latency", 4'b0100, 4'b0000);
    tick("ch2_set", 4'b0100, 4'b0100);
    WHEN_DISABLED[5:4] = 2'd2;
    enable_i[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_i[2] = ~set_i[2];
      rst_i[2] = ~rst_i[2];
      tick("ch2_disabled_hold", 4'b0100, 4'b0100);
    end
    enable_i[2] = 1'b1;
    for (int i = 0; i < 3; i++) tick("ch2_reenable_static", 4'b0100, 4'b0100);
    rst_i[2] = 1'b1;
    tick("ch2_rst_latency", 4'b0100, 4'b0100);
    tick("ch2_rst", 4'b0100, 4'b0000);
    WHEN_DISABLED[5:4] = 2'd1;
    enable_i[2] = 1'b0;
    tick("ch2_dis_latency", 4'b0100, 4'b0000);
    tick("ch2_dis_high", 4'b0100, 4'b0100);
    tick("ch2_dis_high", 4'b0100, 4'b0100);
    WHEN_DISABLED[5:4] = 2'd3;
    tick("", '0, '0);
    tick("ch2_dis_code3_low", 4'b0100, 4'b0000);
    WHEN_DISABLED[5:4] = 2'd1;
    tick("", '0, '0);
    tick("ch2_dis_high_again", 4'b0100, 4'b0100);
    WHEN_DISABLED[5:4] = 2'd0;
    tick("", '0, '0);
    tick("ch2_dis_low", 4'b0100, 4'b0000);
    enable_i[2] = 1'b1;
    tick("", '0, '0);
    tick("ch2_reenable_low", 4'b0100, 4'b0000);

    // Ch3: set edge arriving together with enable 0->1 is honoured.
    WHEN_DISABLED[7:6] = 2'd2;
    enable_i[3] = 1'b0;
    tick("ch3_disabled", 4'b1000, 4'b0000);
    tick("ch3_disabled", 4'b1000, 4'b0000);
    set_i[3]    = 1'b1;
    enable_i[3] = 1'b1;
    tick("ch3_en_edge_latency", 4'b1000, 4'b0000);
    tick("ch3_en_edge_set", 4'b1000, 4'b1000);

    // All high, then asynchronous reset mid-cycle.
    FORCE_SET_WSTB = 1'b1;
    tick("force_all_latency", 4'b1111, 4'b1000);
    FORCE_SET_WSTB = 1'b0;
    tick("force_all", 4'b1111, 4'b1111);
    #2 reset_n_i = 1'b0;
    #1 check("async_reset", out_o, '0);
    set_i = '0;
    rst_i = '0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick("post_reset", 4'b1111, 4'b0000);
    tick("post_reset", 4'b1111, 4'b0000);

`ifdef SRGATE_TIMEOUT_EN
    TIMEOUT = 32'd5;
    set_i[3] = 1'b1;
    tick("to_latency", 4'b1000, 4'b0000);
    for (int i = 0; i < 5; i++) tick("to_high5", 4'b1000, 4'b1000);
    tick("to_expire", 4'b1000, 4'b0000);
    tick("to_stay_low", 4'b1000, 4'b0000);
    set_i[3] = 1'b0;
    tick("", '0, '0);
    tick("to_low", 4'b1000, 4'b0000);
    set_i[3] = 1'b1;
    tick("to_reset_latency", 4'b1000, 4'b0000);
    tick("to_reset_high", 4'b1000, 4'b1000);
    set_i[3] = 1'b0;
    tick("to_reset_high", 4'b1000, 4'b1000);
    set_i[3] = 1'b1;
    tick("to_reset_high", 4'b1000, 4'b1000);
    for (int i = 0; i < 5; i++) tick("to_restarted_high", 4'b1000, 4'b1000);
    tick("to_restart_expire", 4'b1000, 4'b0000);
    TIMEOUT = '0;
    set_i[3] = 1'b0;
    tick("", '0, '0);
    tick("", '0, '0);
    set_i[3] = 1'b1;
    tick("to_off_latency", 4'b1000, 4'b0000);
    for (int i = 0; i < 12; i++) tick("to_off_high", 4'b1000, 4'b1000);
`endif

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
